decode_issue: RTL

- Single-issue RV32I decode/issue stage sitting directly upstream of the register file and feeding execute.
- Accepts fetched instructions over a valid/ready handshake, decodes fields and immediates, and drives the register file read addresses.
- Aligns the registered read data (1-cycle latency) with decoded control, holds it under backpressure, and stalls on RAW/WAW hazards via a scoreboard cleared by writeback.

---
 rtl/core_pkg.sv | 36 +++
 rtl/imm_gen.sv | 21 ++
 rtl/decode_issue.sv | 98 +++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: RV32I opcodes, instruction classes and immediate formats shared by decode/issue.
package core_pkg;
  localparam int RegAddrW = 5;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
    CLS_LOAD, CLS_STORE, CLS_OPIMM, CLS_OP, CLS_ILLEGAL
  } instr_class_t;
  typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;
  function automatic instr_class_t classify(input logic [6:0] opc);
    return opc == OPC_LUI    ? CLS_LUI    :
           opc == OPC_AUIPC  ? CLS_AUIPC  :
           opc == OPC_JAL    ? CLS_JAL    :
           opc == OPC_JALR   ? CLS_JALR   :
           opc == OPC_BRANCH ? CLS_BRANCH :
           opc == OPC_LOAD   ? CLS_LOAD   :
           opc == OPC_STORE  ? CLS_STORE  :
           opc == OPC_OPIMM  ? CLS_OPIMM  :
           opc == OPC_OP     ? CLS_OP     : CLS_ILLEGAL;
  endfunction
  function automatic imm_fmt_t imm_format(input instr_class_t c);
    return c inside {CLS_JALR, CLS_LOAD, CLS_OPIMM} ? FMT_I :
           c == CLS_STORE                           ? FMT_S :
           c == CLS_BRANCH                          ? FMT_B :
           c inside {CLS_LUI, CLS_AUIPC}            ? FMT_U :
           c == CLS_JAL                             ? FMT_J : FMT_NONE;
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: decodes the immediate format of an RV32I instruction and sign-extends it to WordSize.
module imm_gen
  import core_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic [31:0]         instr,
  output logic [WordSize-1:0] imm
);
  imm_fmt_t fmt;
  logic signed [31:0] raw;
  always_comb begin
    fmt = imm_format(classify(instr[6:0]));
    raw = fmt == FMT_I ? {{20{instr[31]}}, instr[31:20]} :
          fmt == FMT_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
          fmt == FMT_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          fmt == FMT_U ? {instr[31:12], 12'd0} :
          fmt == FMT_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} : 32'sd0;
    imm = WordSize'(raw);
  end
endmodule

// File: rtl/decode_issue.sv
// decode_issue: RV32I decode/issue stage; drives RF read addresses, aligns 1-cycle RF data with
// decoded control, skids operands under backpressure and stalls on RAW/WAW via a busy scoreboard.
module decode_issue
  import core_pkg::*;
#(
  parameter int WordSize = 32
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                inValid,
  output logic                inReady,
  input  logic [31:0]         inInstr,
  input  logic [WordSize-1:0] inPc,
  output logic [4:0]          rfSrcA,
  output logic [4:0]          rfSrcB,
  input  logic [WordSize-1:0] rfDataA,
  input  logic [WordSize-1:0] rfDataB,
  output logic                outValid,
  input  logic                outReady,
  output logic [WordSize-1:0] outPc,
  output logic [WordSize-1:0] outRs1Data,
  output logic [WordSize-1:0] outRs2Data,
  output logic [WordSize-1:0] outImm,
  output logic [4:0]          outRd,
  output logic                outWriteRd,
  output logic [3:0]          outClass,
  output logic [2:0]          outFunct3,
  output logic                outFunct7b5,
  output logic                outIllegal,
  input  logic                wbValid,
  input  logic [4:0]          wbRd
);
  instr_class_t cls;
  logic [RegAddrW-1:0] rs1, rs2, rd;
  logic use_rs1, use_rs2, wr_rd, hazard, accept, hold;
  logic [31:1] busy, busy_n;
  logic [31:0] busy_v;
  logic [WordSize-1:0] imm, hold_a, hold_b;
  assign rs1 = inInstr[19:15];
  assign rs2 = inInstr[24:20];
  assign rd = inInstr[11:7];
  assign rfSrcA = rs1;
  assign rfSrcB = rs2;
  assign cls = classify(inInstr[6:0]);
  assign use_rs1 = cls inside {CLS_JALR, CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_OPIMM, CLS_OP};
  assign use_rs2 = cls inside {CLS_BRANCH, CLS_STORE, CLS_OP};
  assign wr_rd = cls inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD, CLS_OPIMM, CLS_OP}
                 && rd != '0;
  assign busy_v = {busy, 1'b0};
  assign hazard = (use_rs1 && busy_v[rs1]) || (use_rs2 && busy_v[rs2]) || (wr_rd && busy_v[rd]);
  assign inReady = !hazard && (!outValid || outReady);
  assign accept = inValid && inReady;
  // RF data is only aligned in the first output cycle; afterwards the skid copy is authoritative
  assign outRs1Data = hold ? hold_a : outValid ? rfDataA : '0;
  assign outRs2Data = hold ? hold_b : outValid ? rfDataB : '0;
  imm_gen #(.WordSize(WordSize)) u_imm (.instr(inInstr), .imm(imm));
  // a set on the same edge as a writeback clear wins
  always_comb
    for (int i = 1; i < 32; i++)
      busy_n[i] = (accept && wr_rd && rd == 5'(i)) || (busy[i] && !(wbValid && wbRd == 5'(i)));
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      busy <= '0;
      outValid <= 1'b0;
      hold <= 1'b0;
      hold_a <= '0;
      hold_b <= '0;
      outPc <= '0;
      outImm <= '0;
      outRd <= '0;
      outWriteRd <= 1'b0;
      outClass <= '0;
      outFunct3 <= '0;
      outFunct7b5 <= 1'b0;
      outIllegal <= 1'b0;
    end else begin
      busy <= busy_n;
      if (accept) begin
        outValid <= 1'b1;
        hold <= 1'b0;
        outPc <= inPc;
        outImm <= imm;
        outRd <= rd;
        outWriteRd <= wr_rd;
        outClass <= cls;
        outFunct3 <= inInstr[14:12];
        outFunct7b5 <= inInstr[30];
        outIllegal <= cls == CLS_ILLEGAL;
      end else if (outValid && outReady) begin
        outValid <= 1'b0;
        hold <= 1'b0;
      end else if (outValid && !hold) begin
        hold <= 1'b1;
        hold_a <= rfDataA;
        hold_b <= rfDataB;
      end
    end
endmodule
